// File: rtl/tow_pkg.sv
// Shared types and encodings for the tug-of-war match controller.
package tow_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT      = 3'd1,
    ST_DARK      = 3'd2,
    ST_PLAY      = 3'd3,
    ST_GLOAT     = 3'd4,
    ST_MATCH_END = 3'd5
  } tow_state_e;

  localparam logic [1:0] LED_OFF   = 2'd0;
  localparam logic [1:0] LED_SN    = 2'd1;
  localparam logic [1:0] LED_SCORE = 2'd2;
  localparam logic [1:0] LED_ON    = 2'd3;

  localparam logic PLAYER_A = 1'b0;
  localparam logic PLAYER_B = 1'b1;

endpackage

// File: rtl/tow_tick_counter.sv
// Counts slow-tick strobes within a phase; done flags the target-th strobe.
module tow_tick_counter #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          slowen,
  input  logic          clr,
  input  logic [CW-1:0] target,
  output logic          done
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear on phase change, otherwise count strobes and hold at the top.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (slowen && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The strobe that brings the count to the target completes the phase.
  assign done = slowen && (cnt_q == (target - CW'(1)));

endmodule

// File: rtl/tow_match_ctrl.sv
// Match-level controller: round sequencing, scoring, false starts, match end.
module tow_match_ctrl
  import tow_pkg::*;
#(
  parameter int WAIT_TICKS     = 2,
  parameter int GLOAT_TICKS    = 2,
  parameter int ROUNDS_TO_WIN  = 3,
  parameter int ROUNDS_W       = 2,
  parameter bit FALSE_START_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                slowen,
  input  logic                random,
  input  logic                btn_a,
  input  logic                btn_b,
  input  logic                winrnd,
  input  logic                win_side,
  input  logic                new_match,
  output logic                leds_on,
  output logic                clear,
  output logic [1:0]          leds_ctrl,
  output logic [ROUNDS_W-1:0] score_a,
  output logic [ROUNDS_W-1:0] score_b,
  output logic                false_start,
  output logic                match_over,
  output logic                match_winner
);

  localparam int TMAX = (WAIT_TICKS > GLOAT_TICKS) ? WAIT_TICKS : GLOAT_TICKS;
  localparam int CW   = $clog2(TMAX + 1);
  localparam logic [ROUNDS_W-1:0] R_MAX = ROUNDS_W'(ROUNDS_TO_WIN);

  tow_state_e          state_q, state_d;
  logic [ROUNDS_W-1:0] score_a_q, score_a_d;
  logic [ROUNDS_W-1:0] score_b_q, score_b_d;
  logic                fs_q, fs_d;
  logic                winner_q, winner_d;
  logic [CW-1:0]       tick_target;
  logic                tick_done;

  // Saturating round-score increment.
  function automatic logic [ROUNDS_W-1:0] sat_inc(input logic [ROUNDS_W-1:0] s);
    if (s != R_MAX) begin
      return s + ROUNDS_W'(1);
    end else begin
      return s;
    end
  endfunction

  // Only WAIT and GLOAT are timed phases; the target is irrelevant elsewhere.
  assign tick_target = (state_q == ST_WAIT) ? CW'(WAIT_TICKS) : CW'(GLOAT_TICKS);

  tow_tick_counter #(.CW(CW)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .slowen (slowen),
    .clr    (state_d != state_q),
    .target (tick_target),
    .done   (tick_done)
  );

  // Next-state, scoring, false-start and winner computation.
  always_comb begin
    state_d   = state_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    fs_d      = 1'b0;
    winner_d  = winner_q;
    case (state_q)
      ST_RESET: begin
        state_d   = ST_WAIT;
        score_a_d = {ROUNDS_W{1'b0}};
        score_b_d = {ROUNDS_W{1'b0}};
      end
      ST_WAIT: begin
        if (tick_done) state_d = ST_DARK;
        else           state_d = ST_WAIT;
      end
      ST_DARK: begin
        if (winrnd) begin
          state_d = ST_GLOAT;
          if (win_side == PLAYER_B) score_b_d = sat_inc(score_b_q);
          else                      score_a_d = sat_inc(score_a_q);
        end else if (FALSE_START_EN && (btn_a || btn_b)) begin
          // A lone early press forfeits to the opponent; a simultaneous one is a void round.
          state_d = ST_GLOAT;
          fs_d    = 1'b1;
          if (btn_a && !btn_b)      score_b_d = sat_inc(score_b_q);
          else if (btn_b && !btn_a) score_a_d = sat_inc(score_a_q);
          else                      score_a_d = score_a_q;
        end else if (slowen && random) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_DARK;
        end
      end
      ST_PLAY: begin
        if (winrnd) begin
          state_d = ST_GLOAT;
          if (win_side == PLAYER_B) score_b_d = sat_inc(score_b_q);
          else                      score_a_d = sat_inc(score_a_q);
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_GLOAT: begin
        if (tick_done) begin
          if ((score_a_q == R_MAX) || (score_b_q == R_MAX)) begin
            state_d  = ST_MATCH_END;
            winner_d = (score_a_q == R_MAX) ? PLAYER_A : PLAYER_B;
          end else begin
            state_d = ST_DARK;
          end
        end else begin
          state_d = ST_GLOAT;
        end
      end
      ST_MATCH_END: begin
        if (new_match) begin
          state_d   = ST_WAIT;
          score_a_d = {ROUNDS_W{1'b0}};
          score_b_d = {ROUNDS_W{1'b0}};
        end else begin
          state_d = ST_MATCH_END;
        end
      end
      default: begin
        state_d   = ST_RESET;
        score_a_d = {ROUNDS_W{1'b0}};
        score_b_d = {ROUNDS_W{1'b0}};
      end
    endcase
  end

  // State and match registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RESET;
      score_a_q <= {ROUNDS_W{1'b0}};
      score_b_q <= {ROUNDS_W{1'b0}};
      fs_q      <= 1'b0;
      winner_q  <= PLAYER_A;
    end else begin
      state_q   <= state_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      fs_q      <= fs_d;
      winner_q  <= winner_d;
    end
  end

  // LED datapath controls decoded from the current state.
  always_comb begin
    leds_on    = 1'b1;
    clear      = 1'b1;
    leds_ctrl  = LED_SN;
    match_over = 1'b0;
    case (state_q)
      ST_RESET:     begin leds_on = 1'b1; clear = 1'b1; leds_ctrl = LED_SN;    end
      ST_WAIT:      begin leds_on = 1'b1; clear = 1'b1; leds_ctrl = LED_ON;    end
      ST_DARK:      begin leds_on = 1'b0; clear = 1'b0; leds_ctrl = LED_OFF;   end
      ST_PLAY:      begin leds_on = 1'b1; clear = 1'b0; leds_ctrl = LED_SCORE; end
      ST_GLOAT:     begin leds_on = 1'b1; clear = 1'b1; leds_ctrl = LED_SCORE; end
      ST_MATCH_END: begin
        leds_on    = 1'b1;
        clear      = 1'b1;
        leds_ctrl  = LED_SCORE;
        match_over = 1'b1;
      end
      default:      begin leds_on = 1'b1; clear = 1'b1; leds_ctrl = LED_SN;    end
    endcase
  end

  assign score_a      = score_a_q;
  assign score_b      = score_b_q;
  assign false_start  = fs_q;
  assign match_winner = winner_q;

endmodule

// File: tb/tb_tow_match_ctrl.sv
// Directed table-driven bench for tow_match_ctrl.
module tb_tow_match_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic slowen, random, btn_a, btn_b, winrnd, win_side, new_match;

  logic       on1, clr1, fs1, mo1, mw1;
  logic [1:0] ctrl1, sa1, sb1;
  logic       on2, clr2, fs2, mo2, mw2;
  logic [1:0] ctrl2, sa2, sb2;

  always #5 clk = ~clk;

  tow_match_ctrl dut (
    .clk(clk), .rst(rst), .slowen(slowen), .random(random),
    .btn_a(btn_a), .btn_b(btn_b), .winrnd(winrnd), .win_side(win_side),
    .new_match(new_match), .leds_on(on1), .clear(clr1), .leds_ctrl(ctrl1),
    .score_a(sa1), .score_b(sb1), .false_start(fs1), .match_over(mo1),
    .match_winner(mw1)
  );

  tow_match_ctrl #(.FALSE_START_EN(1'b0)) dut_nofs (
    .clk(clk), .rst(rst), .slowen(slowen), .random(random),
    .btn_a(btn_a), .btn_b(btn_b), .winrnd(winrnd), .win_side(win_side),
    .new_match(new_match), .leds_on(on2), .clear(clr2), .leds_ctrl(ctrl2),
    .score_a(sa2), .score_b(sb2), .false_start(fs2), .match_over(mo2),
    .match_winner(mw2)
  );

  wire [10:0] obs1 = {on1, clr1, ctrl1, sa1, sb1, fs1, mo1, mw1};
  wire [10:0] obs2 = {on2, clr2, ctrl2, sa2, sb2, fs2, mo2, mw2};

  // {leds_on, clear, leds_ctrl} per state
  localparam logic [3:0] L_RESET = 4'b1101;
  localparam logic [3:0] L_WAIT  = 4'b1111;
  localparam logic [3:0] L_DARK  = 4'b0000;
  localparam logic [3:0] L_PLAY  = 4'b1010;
  localparam logic [3:0] L_GLOAT = 4'b1110;
  localparam logic [3:0] L_ME    = 4'b1110;

  // inputs {slowen, random, btn_a, btn_b, winrnd, win_side, new_match}
  localparam logic [6:0] I_NONE = 7'b0000000;
  localparam logic [6:0] I_SL   = 7'b1000000;
  localparam logic [6:0] I_SLR  = 7'b1100000;
  localparam logic [6:0] I_BA   = 7'b0010000;
  localparam logic [6:0] I_BB   = 7'b0001000;
  localparam logic [6:0] I_W0   = 7'b0000100;
  localparam logic [6:0] I_W1   = 7'b0000110;
  localparam logic [6:0] I_NM   = 7'b0000001;

  typedef struct {
    logic [6:0]  in;
    logic [10:0] exp;
  } vec_t;

  localparam int NV = 39;
  vec_t vecs[NV];

  int tests  = 0;
  int failed = 0;

  function automatic logic [10:0] ex(input logic [3:0] led, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic fs,
                                     input logic mo, input logic mw);
    return {led, sa, sb, fs, mo, mw};
  endfunction

  function automatic vec_t mk(input logic [6:0] in, input logic [10:0] e);
    vec_t v;
    v.in  = in;
    v.exp = e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s got %b expected %b (on,clr,ctrl,sa,sb,fs,mo,mw)", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] in);
    {slowen, random, btn_a, btn_b, winrnd, win_side, new_match} = in;
  endtask

  initial begin
    vecs[0]  = mk(I_NONE,           ex(L_WAIT,  2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
    vecs[1]  = mk(I_SL,             ex(L_WAIT,  2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
    vecs[2]  = mk(I_SL,             ex(L_DARK,  2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
    vecs[3]  = mk(I_SL,             ex(L_DARK,  2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
    vecs[4]  = mk(I_SLR,            ex(L_PLAY,  2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
    vecs[5]  = mk(I_BA,             ex(L_PLAY,  2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
    vecs[6]  = mk(I_W1,             ex(L_GLOAT, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0));
    vecs[7]  = mk(I_W0,             ex(L_GLOAT, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0));
    vecs[8]  = mk(I_SL,             ex(L_GLOAT, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0));
    vecs[9]  = mk(I_SL,             ex(L_DARK,  2'd0, 2'd1, 1'b0, 1'b0, 1'b0));
    vecs[10] = mk(I_BA,             ex(L_GLOAT, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0));
    vecs[11] = mk(I_NONE,           ex(L_GLOAT, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0));
    vecs[12] = mk(I_SL,             ex(L_GLOAT, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0));
    vecs[13] = mk(I_SL,             ex(L_DARK,  2'd0, 2'd2, 1'b0, 1'b0, 1'b0));
    vecs[14] = mk(I_BA|I_BB|I_SLR,  ex(L_GLOAT, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0));
    vecs[15] = mk(I_SL,             ex(L_GLOAT, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0));
    vecs[16] = mk(I_SL,             ex(L_DARK,  2'd0, 2'd2, 1'b0, 1'b0, 1'b0));
    vecs[17] = mk(I_W0|I_SLR,       ex(L_GLOAT, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0));
    vecs[18] = mk(I_SL,             ex(L_GLOAT, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0));
    vecs[19] = mk(I_SL,             ex(L_DARK,  2'd1, 2'd2, 1'b0, 1'b0, 1'b0));
    vecs[20] = mk(I_SLR,            ex(L_PLAY,  2'd1, 2'd2, 1'b0, 1'b0, 1'b0));
    vecs[21] = mk(I_W0,             ex(L_GLOAT, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0));
    vecs[22] = mk(I_SL,             ex(L_GLOAT, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0));
    vecs[23] = mk(I_SL,             ex(L_DARK,  2'd2, 2'd2, 1'b0, 1'b0, 1'b0));
    vecs[24] = mk(I_W0,             ex(L_GLOAT, 2'd3, 2'd2, 1'b0, 1'b0, 1'b0));
    vecs[25] = mk(I_SL,             ex(L_GLOAT, 2'd3, 2'd2, 1'b0, 1'b0, 1'b0));
    vecs[26] = mk(I_SL,             ex(L_ME,    2'd3, 2'd2, 1'b0, 1'b1, 1'b0));
    vecs[27] = mk(I_W1,             ex(L_ME,    2'd3, 2'd2, 1'b0, 1'b1, 1'b0));
    vecs[28] = mk(I_BA|I_SL,        ex(L_ME,    2'd3, 2'd2, 1'b0, 1'b1, 1'b0));
    vecs[29] = mk(I_NM,             ex(L_WAIT,  2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
    vecs[30] = mk(I_SL,             ex(L_WAIT,  2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
    vecs[31] = mk(I_SL,             ex(L_DARK,  2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
    vecs[32] = mk(I_W0,             ex(L_GLOAT, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0));
    vecs[33] = mk(I_SL,             ex(L_GLOAT, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0));
    vecs[34] = mk(I_SL,             ex(L_DARK,  2'd1, 2'd0, 1'b0, 1'b0, 1'b0));
    vecs[35] = mk(I_W0,             ex(L_GLOAT, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0));
    vecs[36] = mk(I_SL,             ex(L_GLOAT, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0));
    vecs[37] = mk(I_SL,             ex(L_DARK,  2'd2, 2'd0, 1'b0, 1'b0, 1'b0));
    vecs[38] = mk(I_SLR,            ex(L_PLAY,  2'd2, 2'd0, 1'b0, 1'b0, 1'b0));

    rst = 1'b1;
    drive(I_NONE);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", obs1, ex(L_RESET, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].in);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), obs1, vecs[i].exp);
      if (i == 10) begin
        // Same stimulus with false starts disabled: the press is ignored, still DARK.
        check("nofs_dark_press", obs2, ex(L_DARK, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0));
      end
    end

    // Asynchronous reset mid-PLAY with score_a = 2.
    drive(I_NONE);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_mid_play", obs1, ex(L_RESET, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    check("held_in_reset", obs1, ex(L_RESET, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_to_wait", obs1, ex(L_WAIT, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/tow_match_ctrl.md
# tow_match_ctrl

Parametrised match-level master controller for the tug-of-war game. It sequences each round through reset, wait, dark-random, play and gloat phases, and drives the LED datapath controls. It also adds per-player round scoring, false-start detection and a best-of-N match end. It sits between the debounced player buttons / slow-tick generator and the LED/score datapath. It replaces the single-round controller.

## Interface
- `WAIT_TICKS`, default 2: slowen pulses spent in WAIT after reset or new match; legal range ≥1.
- `GLOAT_TICKS`, default 2: slowen pulses spent in GLOAT after each round; legal range ≥1.
- `ROUNDS_TO_WIN`, default 3: round wins that end the match; legal range ≥1.
- `ROUNDS_W`, default 2: score width; must satisfy 2^ROUNDS_W > ROUNDS_TO_WIN.
- `FALSE_START_EN`, default 1: 1 = a press during DARK forfeits the round; 0 = presses during DARK are ignored.
- `clk` in 1: clock clk.
- `rst` in 1: reset rst, asynchronous, active-high.
- `slowen` in 1: one-cycle slow tick strobe.
- `random` in 1: random bit, sampled only with slowen in DARK.
- `btn_a`, `btn_b` in 1 each: synchronised one-cycle press pulses.
- `winrnd` in 1: one-cycle pulse from the datapath when the rope reaches an end.
- `win_side` in 1: valid with winrnd; 0 = A won, 1 = B won.
- `new_match` in 1: one-cycle request to restart the match from MATCH_END.
- `leds_on` out 1: LED enable.
- `clear` out 1: datapath position clear.
- `leds_ctrl` out 2: 0 off, 1 self-test, 2 score, 3 all on.
- `score_a`, `score_b` out ROUNDS_W each: rounds won.
- `false_start` out 1: one-cycle pulse on a detected false start.
- `match_over` out 1: high in MATCH_END.
- `match_winner` out 1: 0 = A, 1 = B; valid while match_over.

## Operation
- States: RESET, WAIT, DARK, PLAY, GLOAT, MATCH_END. An internal tick counter counts slowen and clears on every state change.
- RESET → WAIT on the first clk edge with rst low. The reset state also clears both scores.
- WAIT → DARK on the WAIT_TICKS-th slowen.
- DARK, priority highest first:
  - winrnd: award the round to win_side, go to GLOAT.
  - False start, with FALSE_START_EN=1:
    - exactly one button pressed: award the round to the opponent, pulse false_start, go to GLOAT.
    - both buttons pressed in the same cycle: pulse false_start, go to GLOAT, no score change.
  - slowen & random: go to PLAY.
- PLAY → GLOAT on winrnd, awarding the round to win_side. Buttons are ignored by this block in PLAY.
- GLOAT → MATCH_END on the GLOAT_TICKS-th slowen if either score equals ROUNDS_TO_WIN; otherwise → DARK.
- MATCH_END → WAIT on new_match, clearing both scores in the same edge. Otherwise MATCH_END holds.
- Scores increment by 1 and saturate at ROUNDS_TO_WIN. An increment is never lost or doubled.
- Output decode (leds_on / clear / leds_ctrl):
  - RESET: 1 / 1 / 1
  - WAIT: 1 / 1 / 3
  - DARK: 0 / 0 / 0
  - PLAY: 1 / 0 / 2
  - GLOAT: 1 / 1 / 2
  - MATCH_END: 1 / 1 / 2
- Illegal state encodings → RESET on the next edge.

## Timing
- State, tick counter, scores, false_start and match_winner are registered.
- leds_on, clear, leds_ctrl and match_over are decoded from the state register.
- Reset values: state RESET, leds_on 1, clear 1, leds_ctrl 1, scores 0, false_start 0, match_over 0, match_winner 0.
- One-cycle latency: an input event at edge N sets the new state and score at edge N. The decoded outputs change in the same cycle.
- match_winner is registered on the GLOAT → MATCH_END edge.
- winrnd and slowen in the same DARK cycle: winrnd wins.
- A button and slowen&random in the same cycle: the false start wins.
- winrnd outside DARK/PLAY is ignored. new_match outside MATCH_END is ignored.
- rst mid-round returns asynchronously to RESET and clears the scores.

## Structure
- Shared package `tow_pkg` holds:
  - the state enum;
  - the leds_ctrl encodings LED_OFF=0, LED_SN=1, LED_SCORE=2, LED_ON=3;
  - the player encoding PLAYER_A=0, PLAYER_B=1.
- One sub-module, `tow_tick_counter`:
  - counts slowen pulses;
  - sync clear on state change;
  - `done` output on reaching a target tick count;
  - width $clog2(max(WAIT_TICKS,GLOAT_TICKS)+1).

## Test plan
- Defaults, rst released, 2 slowen → state DARK with leds 0/0/0. With random=1, the next slowen → PLAY with leds 1/0/2.
- In PLAY, winrnd with win_side=1 → score_b=1, GLOAT. After 2 slowen → DARK.
- In DARK, btn_a pulse → false_start pulse, score_b +1. With FALSE_START_EN=0 → no change.
- btn_a and btn_b in the same DARK cycle → false_start pulse, scores unchanged, GLOAT.
- A wins 3 rounds → after GLOAT, match_over=1 and match_winner=0. Extra winrnd → scores unchanged. new_match → scores 0, WAIT.
- rst asserted mid-PLAY with score_a=2 → immediate RESET outputs 1/1/1 and scores 0.
